uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 194 +++++++++++++++++++
 tb/tb_uart_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART boot loader: receives an A5-framed program image over 8N1 serial,
// writes it word by word into instruction ROM, then releases the core from reset.
module uart_loader #(
  parameter int CLK_DIV   = 434,
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  output logic        rom_we_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        core_rst_n_o,
  output logic        busy_o,
  output logic        err_o
);
  // state | meaning
  // RX_IDLE  | waiting for a falling edge on the synchronized line
  // RX_START | timing to the start-bit midpoint, rejecting false starts
  // RX_DATA  | sampling 8 data bits, LSB first
  // RX_STOP  | sampling the stop bit
  // P_SYNC   | hunting for the A5 sync byte
  // P_LEN0/1 | capturing word count, low byte first
  // P_DATA   | assembling words and writing ROM
  // P_CSUM   | comparing the XOR checksum
  // P_DONE   | image loaded, core released; A5 reloads
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_SYNC, P_LEN0, P_LEN1, P_DATA, P_CSUM, P_DONE} p_state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t   r_rx_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_byte_valid, r_frame_err;
  logic [7:0]  r_byte;

  p_state_t    r_pstate;
  logic [15:0] r_count, r_widx;
  logic [1:0]  r_bcnt;
  logic [31:0] r_word;
  logic [7:0]  r_csum;
  logic [15:0] w_len;
  logic [31:0] w_word_next;

  assign w_len       = {r_byte, r_count[7:0]};
  assign w_word_next = {r_byte, r_word[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte       <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_cnt      <= HALF_M1;
          end
        end
        RX_START: begin
          if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
          else if (r_rx_sync) r_rx_state <= RX_IDLE;
          else begin
            r_rx_state <= RX_DATA;
            r_cnt      <= FULL_M1;
            r_bit_idx  <= '0;
          end
        end
        RX_DATA: begin
          if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
          else begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_cnt   <= FULL_M1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
          else begin
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate     <= P_SYNC;
      r_count      <= '0;
      r_widx       <= '0;
      r_bcnt       <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      rom_we_o     <= 1'b0;
      rom_waddr_o  <= '0;
      rom_wdata_o  <= '0;
      core_rst_n_o <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rom_we_o <= 1'b0;
      if (r_frame_err) begin
        err_o        <= 1'b1;
        r_pstate     <= P_SYNC;
        busy_o       <= 1'b0;
        core_rst_n_o <= 1'b0;
      end else if (r_byte_valid) begin
        case (r_pstate)
          P_SYNC, P_DONE: begin
            if (r_byte == 8'hA5) begin
              r_pstate     <= P_LEN0;
              r_widx       <= '0;
              r_bcnt       <= '0;
              r_csum       <= '0;
              err_o        <= 1'b0;
              busy_o       <= 1'b1;
              core_rst_n_o <= 1'b0;
            end
          end
          P_LEN0: begin
            r_count[7:0] <= r_byte;
            r_pstate     <= P_LEN1;
          end
          P_LEN1: begin
            r_count <= w_len;
            if (w_len == 16'd0 || {1'b0, w_len} > MAX_LEN) begin
              err_o    <= 1'b1;
              busy_o   <= 1'b0;
              r_pstate <= P_SYNC;
            end else begin
              r_pstate <= P_DATA;
            end
          end
          P_DATA: begin
            r_csum <= r_csum ^ r_byte;
            r_word <= w_word_next;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              rom_we_o    <= 1'b1;
              rom_waddr_o <= {14'd0, r_widx, 2'b00};
              rom_wdata_o <= w_word_next;
              r_widx      <= r_widx + 16'd1;
              if (r_widx == r_count - 16'd1) r_pstate <= P_CSUM;
            end
          end
          P_CSUM: begin
            busy_o <= 1'b0;
            if (r_byte == r_csum) begin
              r_pstate     <= P_DONE;
              core_rst_n_o <= 1'b1;
            end else begin
              err_o    <= 1'b1;
              r_pstate <= P_SYNC;
            end
          end
          default: r_pstate <= P_SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frames plus randomized images
// compared against a word-list/checksum model of the load protocol.
module tb_uart_loader;
  localparam int CLK_DIV   = 8;
  localparam int MAX_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        rom_we_o;
  logic [31:0] rom_waddr_o, rom_wdata_o;
  logic        core_rst_n_o, busy_o, err_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] wq[$];

  uart_loader #(.CLK_DIV(CLK_DIV), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(uart_rx),
    .rom_we_o(rom_we_o), .rom_waddr_o(rom_waddr_o), .rom_wdata_o(rom_wdata_o),
    .core_rst_n_o(core_rst_n_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && rom_we_o) wq.push_back({rom_waddr_o, rom_wdata_o});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".we"},     rom_we_o,     1'b0);
    chk({tag, ".waddr"},  rom_waddr_o,  32'd0);
    chk({tag, ".wdata"},  rom_wdata_o,  32'd0);
    chk({tag, ".corerst"}, core_rst_n_o, 1'b0);
    chk({tag, ".busy"},   busy_o,       1'b0);
    chk({tag, ".err"},    err_o,        1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_writes(input string tag, input logic [63:0] exp[$]);
    chk({tag, ".nwrites"}, 64'(wq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      chk($sformatf("%s.write%0d", tag, i), wq[i], exp[i]);
  endtask

  // Model: a frame of words yields one write per word at index*4; the core is
  // released only when the checksum byte equals the XOR of every data byte.
  task automatic run_random(input int nw, input bit bad);
    logic [7:0]  fr[$];
    logic [63:0] exp[$];
    logic [7:0]  cs, b;
    logic [31:0] w;
    cs = 8'd0;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      fr.push_back(b);
    end
    fr.push_back(8'hA5);
    fr.push_back(8'(nw));
    fr.push_back(8'(nw >> 8));
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[7:0] = 8'hA5;
      exp.push_back({32'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        fr.push_back(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
    fr.push_back(bad ? cs ^ 8'($urandom_range(1, 255)) : cs);
    wq.delete();
    send_bytes(fr);
    chk_writes($sformatf("rand_nw%0d", nw), exp);
    chk("rand.err",     err_o,        bad);
    chk("rand.corerst", core_rst_n_o, !bad);
    chk("rand.busy",    busy_o,       1'b0);
  endtask

  initial begin
    logic [63:0] exp[$];
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word image with correct checksum
    wq.delete();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00});
    chk("good.busy_before_csum",    busy_o,       1'b1);
    chk("good.corerst_before_csum", core_rst_n_o, 1'b0);
    send_byte(8'h7C, 1'b1);
    exp = '{{32'h0, 32'h00000013}, {32'h4, 32'h0000006F}};
    chk_writes("good", exp);
    chk("good.corerst", core_rst_n_o, 1'b1);
    chk("good.err",     err_o,        1'b0);
    chk("good.busy",    busy_o,       1'b0);

    // Reload from DONE, then abort with reset mid-word
    send_byte(8'hA5, 1'b1);
    chk("reload.corerst", core_rst_n_o, 1'b0);
    chk("reload.busy",    busy_o,       1'b1);
    wq.delete();
    send_bytes('{8'h01, 8'h00, 8'h11, 8'h22});
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midload_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_bytes('{8'h33, 8'h44, 8'h66});
    chk("midload.nwrites", 64'(wq.size()), 64'd0);
    chk("midload.busy",    busy_o,       1'b0);
    chk("midload.corerst", core_rst_n_o, 1'b0);

    // Bad checksum
    do_reset();
    wq.delete();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D});
    chk_writes("badcs", exp);
    chk("badcs.err",     err_o,        1'b1);
    chk("badcs.corerst", core_rst_n_o, 1'b0);
    chk("badcs.busy",    busy_o,       1'b0);
    send_byte(8'hA5, 1'b1);
    chk("badcs.resync_err",  err_o,  1'b0);
    chk("badcs.resync_busy", busy_o, 1'b1);

    // Length boundaries: 0, MAX+1, MAX
    do_reset();
    wq.delete();
    send_bytes('{8'hA5, 8'h00, 8'h00});
    chk("len0.err",  err_o,  1'b1);
    chk("len0.busy", busy_o, 1'b0);
    send_byte(8'hA5, 1'b1);
    chk("len17.err_cleared", err_o, 1'b0);
    send_bytes('{8'h11, 8'h00});
    chk("len17.err",  err_o,  1'b1);
    chk("len17.busy", busy_o, 1'b0);
    chk("len.nwrites", 64'(wq.size()), 64'd0);
    send_bytes('{8'hA5, 8'h10, 8'h00});
    chk("len16.err",  err_o,  1'b0);
    chk("len16.busy", busy_o, 1'b1);

    // Short glitch on idle line is ignored while waiting for length
    do_reset();
    wq.delete();
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    chk("glitch.busy", busy_o, 1'b1);
    chk("glitch.err",  err_o,  1'b0);
    send_bytes('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13});
    exp = '{{32'h0, 32'h00000013}};
    chk_writes("glitch", exp);
    chk("glitch.corerst", core_rst_n_o, 1'b1);

    // Framing error inside data
    do_reset();
    wq.delete();
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h13});
    send_byte(8'h00, 1'b0);
    chk("frame.err",     err_o,        1'b1);
    chk("frame.busy",    busy_o,       1'b0);
    chk("frame.corerst", core_rst_n_o, 1'b0);
    send_bytes('{8'h00, 8'h00, 8'h13});
    chk("frame.nwrites", 64'(wq.size()), 64'd0);
    chk("frame.err_held", err_o, 1'b1);

    // Randomized images, back to back (reload from DONE or resync from SYNC)
    do_reset();
    run_random(MAX_WORDS, 1'b0);
    for (int t = 0; t < 4; t++)
      run_random($urandom_range(1, MAX_WORDS), ($urandom_range(0, 3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
